// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the two-port memory arbiter: FSM state
//               encoding, port identifiers and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;

    // Port identifiers, also used as the stored value of last_grant
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One-hot grant {d, f} to port id
    function automatic logic port_of(input logic [1:0] grant);
        return grant[1] ? PORT_D : PORT_F;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-requester round-robin picker. A lone requester always
//               wins; on a tie the port that was not granted last wins.
//               Grant is one-hot: bit 0 = fetch, bit 1 = data.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       i_req_f,
    input  logic       i_req_d,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // Pure combinational selection; nothing is granted when nobody asks
    always_comb begin
        o_grant = 2'b00;
        if (i_req_f && i_req_d) begin
            o_grant = (i_last_grant == PORT_D) ? 2'b01 : 2'b10;
        end else if (i_req_f) begin
            o_grant = 2'b01;
        end else if (i_req_d) begin
            o_grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a fetch port and a data port onto one single-ported
//               memory. Each transaction walks IDLE -> ACCESS -> WAIT (MEM_LAT
//               cycles) -> DONE; all memory strobes, acks and read data are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    // fetch port
    input  logic          f_req,
    input  logic          f_we,
    input  logic [AW-1:0] f_addr,
    input  logic [DW-1:0] f_wdata,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // WAIT counts down from MEM_LAT-1 to 0, giving exactly MEM_LAT cycles
    localparam logic [2:0] c_lat_load = 3'(MEM_LAT - 1);

    state_t        state_q,      state_d;
    logic [2:0]    cnt_q,        cnt_d;
    logic          port_q,       port_d;
    logic          we_q,         we_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic          last_grant_q, last_grant_d;
    logic          mem_en_q,     mem_en_d;
    logic          mem_we_q,     mem_we_d;
    logic          f_ack_q,      f_ack_d;
    logic          d_ack_q,      d_ack_d;
    logic          busy_q,       busy_d;
    logic [DW-1:0] f_rdata_q,    f_rdata_d;
    logic [DW-1:0] d_rdata_q,    d_rdata_d;

    logic [1:0]    w_grant;

    rr_pick2 u_pick (
        .i_req_f      (f_req),
        .i_req_d      (d_req),
        .i_last_grant (last_grant_q),
        .o_grant      (w_grant)
    );

    // Next-state logic; every output is computed one cycle ahead so it can be registered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Latching the command here isolates the access from later port changes
                if (w_grant != 2'b00) begin
                    port_d   = port_of(w_grant);
                    we_d     = w_grant[1] ? d_we    : f_we;
                    addr_d   = w_grant[1] ? d_addr  : f_addr;
                    wdata_d  = w_grant[1] ? d_wdata : f_wdata;
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d   = c_lat_load;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (!we_q) begin
                        if (port_q == PORT_F) begin
                            f_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    f_ack_d = (port_q == PORT_F);
                    d_ack_d = (port_q == PORT_D);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                last_grant_d = port_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            port_q       <= PORT_F;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= PORT_D;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            busy_q       <= busy_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // The latched command doubles as the held memory address/data bus
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire
